// File: rtl/atan_pkg.sv
// atan_pkg: shared FSM state type, fixed-point widths and constants for atan_poly_driver (ATAN_SIGN_EN widens the result)
package atan_pkg;
  typedef enum logic [2:0] {IDLE, SQUARE, MUL_WAIT, SCALE, OUT} state_e;
  localparam int Q_FRAC = 15;
  localparam int POW_W = 16;
  localparam int P_W = 23;
  localparam int P_SHIFT = 7;
  localparam logic [POW_W-1:0] C1_DEF = 16'h7F67;
  localparam logic [POW_W-1:0] X_MAX = 16'h8000;
`ifdef ATAN_SIGN_EN
  localparam int OUT_W = POW_W + 1;
`else
  localparam int OUT_W = POW_W;
`endif
endpackage

// File: rtl/atan_poly_driver.sv
// atan_poly_driver: evaluates atan(x) ~ x*(C1 - A*x^2) around an external constant multiplier; ATAN_SIGN_EN adds signed output
module atan_poly_driver
  import atan_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter logic [POW_W-1:0] C1 = C1_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [POW_W-1:0] in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_atan,
  output logic [POW_W-1:0] atan_poly_pow_2,
  input  logic [P_W-1:0]   mul_A_p,
`ifdef ATAN_SIGN_EN
  input  logic             in_sign,
  output logic             out_sign,
`endif
  output logic             busy
);
  localparam int CW = $clog2(MUL_LAT + 2);
  state_e           state_q, state_d;
  logic [POW_W-1:0] x_q, x_d, pow2_q, pow2_d, t_q, t_d, d_mag, mag;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [OUT_W-1:0] res_q, res_d;
  logic             sign_q, sign_d;
  logic             unused_p;
  assign unused_p = ^mul_A_p[P_SHIFT-1:0];
  assign in_ready = (state_q == IDLE) && !rst;
  assign out_valid = state_q == OUT;
  assign busy = state_q != IDLE;
  assign atan_poly_pow_2 = pow2_q;
  assign out_atan = res_q;
  assign d_mag = C1 > t_q ? C1 - t_q : '0;
  assign mag = POW_W'((32'(x_q) * 32'(d_mag)) >> Q_FRAC);
`ifdef ATAN_SIGN_EN
  assign out_sign = sign_q;
`endif
  // state and datapath registers; reset aborts any operand in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      x_q <= '0;
      pow2_q <= '0;
      t_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      sign_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      pow2_q <= pow2_d;
      t_q <= t_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
      sign_q <= sign_d;
    end
  end
  // next-state and datapath updates: clamp, square, wait on multiplier, scale, hold result
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    pow2_d = pow2_q;
    t_d = t_q;
    cnt_d = cnt_q;
    res_d = res_q;
    sign_d = sign_q;
    case (state_q)
      IDLE: if (in_valid) begin
        x_d = in_x > X_MAX ? X_MAX : in_x;
`ifdef ATAN_SIGN_EN
        sign_d = in_sign;
`endif
        state_d = SQUARE;
      end
      SQUARE: begin
        pow2_d = POW_W'((32'(x_q) * 32'(x_q)) >> Q_FRAC);
        cnt_d = '0;
        state_d = MUL_WAIT;
      end
      MUL_WAIT: if (cnt_q == CW'(MUL_LAT)) begin
        t_d = mul_A_p[P_W-1:P_SHIFT];
        state_d = SCALE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      SCALE: begin
`ifdef ATAN_SIGN_EN
        res_d = sign_q ? -{1'b0, mag} : {1'b0, mag};
`else
        res_d = mag;
`endif
        state_d = OUT;
      end
      OUT: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule
